// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: one radix-2 step per clock,
// signed operations run on magnitudes and are negated on the way into the result register.
module muldiv_unit #(
   parameter int WORDSIZE = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [2:0]          funct3,
   input  logic [WORDSIZE-1:0] rs1_data,
   input  logic [WORDSIZE-1:0] rs2_data,
   input  logic [4:0]          rd_addr,
   input  logic                flush,
   output logic                busy,
   output logic                done,
   output logic [WORDSIZE-1:0] result,
   output logic [4:0]          wb_addr,
   output logic                wb_we
);

   localparam int W  = WORDSIZE;
   localparam int CW = $clog2(WORDSIZE);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           neg_q, neg_d;
   logic [4:0]     rd_q, rd_d;
   logic [W-1:0]   result_q, result_d;

   logic           sgnA, sgnB, divZero, divOvf;
   logic [W-1:0]   magA, magB, specialVal;
   logic [W:0]     addSum, remShift;
   logic [W-1:0]   diffLow;
   logic           remGeq;
   logic [2*W-1:0] stepVal, fullSigned;
   logic [W-1:0]   divRaw, divOut, finalVal;

   // Operand conditioning at acceptance: sign extraction, magnitudes and the
   // divide-by-zero / signed-overflow shortcuts that bypass the iteration.
   always_comb begin
      sgnA = rs1_data[W-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                              (funct3 == 3'b100) | (funct3 == 3'b110));
      sgnB = rs2_data[W-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                              (funct3 == 3'b110));
      magA = sgnA ? -rs1_data : rs1_data;
      magB = sgnB ? -rs2_data : rs2_data;
      divZero = funct3[2] & (rs2_data == '0);
      divOvf  = funct3[2] & ~funct3[0] & (rs1_data == {1'b1, {(W-1){1'b0}}}) &
                (rs2_data == '1);
      if (divZero)
         specialVal = funct3[1] ? rs1_data : '1;
      else
         specialVal = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
   end

   // One iteration: shift-add for multiply ({hi, multiplier} shifts right),
   // restoring subtract for divide ({remainder, quotient} shifts left).
   always_comb begin
      addSum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      remShift = prod_q[2*W-1:W-1];
      remGeq   = remShift >= {1'b0, opnd_q};
      diffLow  = remShift[W-1:0] - opnd_q;
      if (!op_q[2])
         stepVal = {addSum, prod_q[W-1:1]};
      else if (remGeq)
         stepVal = {diffLow, prod_q[W-2:0], 1'b1};
      else
         stepVal = {remShift[W-1:0], prod_q[W-2:0], 1'b0};
   end

   // Result selection from the final step; MUL never sets neg_q so the low half is raw.
   always_comb begin
      fullSigned = neg_q ? -stepVal : stepVal;
      divRaw     = op_q[1] ? stepVal[2*W-1:W] : stepVal[W-1:0];
      divOut     = neg_q ? -divRaw : divRaw;
      if (op_q[2])
         finalVal = divOut;
      else if (op_q[1:0] == 2'b00)
         finalVal = fullSigned[W-1:0];
      else
         finalVal = fullSigned[2*W-1:W];
   end

   // Control FSM and next-state for all datapath registers.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rd_d     = rd_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d   = funct3;
               rd_d   = rd_addr;
               neg_d  = (funct3 == 3'b110) ? sgnA : (sgnA ^ sgnB);
               opnd_d = magB;
               prod_d = {{W{1'b0}}, magA};
               cnt_d  = '0;
               if (divZero || divOvf) begin
                  state_d  = DONE;
                  result_d = specialVal;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               prod_d = stepVal;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(W - 1)) begin
                  state_d  = DONE;
                  result_d = finalVal;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         opnd_q   <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rd_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rd_q     <= rd_d;
         result_q <= result_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE) && !flush;
   assign wb_we   = done && (rd_q != 5'd0);
   assign wb_addr = rd_q;
   assign result  = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, arithmetic results,
// shortcut cases, write-back gating, start masking, async reset and flush.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_addr;
   logic        flush;
   logic        busy, done, wb_we;
   logic [31:0] result;
   logic [4:0]  wb_addr;

   int testCount = 0;
   int failCount = 0;
   int cycles;
   logic sawDone;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
   localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   muldiv_unit #(.WORDSIZE(32)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
      .flush(flush), .busy(busy), .done(done), .result(result),
      .wb_addr(wb_addr), .wb_we(wb_we)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
      @(negedge clk);
      start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_addr = rd;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after acceptance until done rises, bounded so a stuck DUT still ends.
   task automatic waitDone(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic watchNoDone(output logic seen);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen = seen | done;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] expRes, input int expCycles);
      int n;
      applyStimulus(f3, a, b, rd);
      waitDone(n);
      check({tag, ".latency"}, n, expCycles);
      check({tag, ".done"}, {31'b0, done}, 32'd1);
      check({tag, ".result"}, result, expRes);
      check({tag, ".wb_we"}, {31'b0, wb_we}, {31'b0, rd != 5'd0});
      check({tag, ".wb_addr"}, {27'b0, wb_addr}, {27'b0, rd});
      @(posedge clk);
      #1;
      check({tag, ".done_pulse"}, {30'b0, done, wb_we}, 32'd0);
      check({tag, ".idle"}, {31'b0, busy}, 32'd0);
      check({tag, ".hold"}, result, expRes);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
      rs1_data = '0; rs2_data = '0; rd_addr = '0;
      #1;
      check("reset.busy", {31'b0, busy}, 32'd0);
      check("reset.done", {31'b0, done}, 32'd0);
      check("reset.wb_we", {31'b0, wb_we}, 32'd0);
      check("reset.wb_addr", {27'b0, wb_addr}, 32'd0);
      check("reset.result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Multiply family
      applyStimulus(MUL, 32'd7, 32'hFFFFFFFD, 5'd5);
      check("mul.busy_after_accept", {31'b0, busy}, 32'd1);
      waitDone(cycles);
      check("mul.latency", cycles, 32);
      check("mul.result", result, 32'hFFFFFFEB);
      check("mul.we", {31'b0, wb_we}, 32'd1);
      check("mul.wb_addr", {27'b0, wb_addr}, 32'd5);
      @(posedge clk); #1;
      check("mul.done_once", {30'b0, done, wb_we}, 32'd0);

      checkOutput("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 32);
      checkOutput("mulh", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 32);
      checkOutput("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 32);

      // Divide family
      checkOutput("div", DIV, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFD, 32);
      checkOutput("rem", REM, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFF, 32);
      checkOutput("divu", DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 32);
      checkOutput("remu", REMU, 32'd100, 32'd7, 5'd9, 32'd2, 32);

      // Shortcut cases finish right after acceptance
      checkOutput("divu0", DIVU, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 0);
      checkOutput("remu0", REMU, 32'd5, 32'd0, 5'd11, 32'd5, 0);
      checkOutput("divovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0);
      checkOutput("removf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 0);

      // rd=0 suppresses write enable; start during CALC is masked
      applyStimulus(MUL, 32'd3, 32'd4, 5'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         start = 1'b1; funct3 = DIVU; rs1_data = 32'd99; rs2_data = 32'd0; rd_addr = 5'd20;
         @(posedge clk); #1;
         check("rd0.busy_start_masked", {30'b0, busy, done}, 32'd2);
      end
      start = 1'b0;
      waitDone(cycles);
      check("rd0.latency", cycles, 29);
      check("rd0.done", {31'b0, done}, 32'd1);
      check("rd0.result", result, 32'd12);
      check("rd0.wb_we", {31'b0, wb_we}, 32'd0);
      check("rd0.wb_addr", {27'b0, wb_addr}, 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of CALC
      applyStimulus(MUL, 32'd6, 32'd7, 5'd3);
      repeat (9) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst.busy", {31'b0, busy}, 32'd0);
      check("arst.done", {31'b0, done}, 32'd0);
      check("arst.result", result, 32'd0);
      check("arst.wb_addr", {27'b0, wb_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      watchNoDone(sawDone);
      check("arst.no_done", {31'b0, sawDone}, 32'd0);

      // Flush in CALC step 5
      applyStimulus(MUL, 32'd9, 32'd9, 5'd4);
      repeat (4) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      check("flush.busy_before_edge", {30'b0, busy, done}, 32'd2);
      @(posedge clk); #1;
      check("flush.busy_after_edge", {31'b0, busy}, 32'd0);
      flush = 1'b0;
      watchNoDone(sawDone);
      check("flush.no_done", {31'b0, sawDone}, 32'd0);
      check("flush.result_kept", result, 32'd0);

      checkOutput("post_flush_mul", MUL, 32'd6, 32'd7, 5'd3, 32'd42, 32);

      // flush and start together in IDLE discard the start
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = DIVU; rs1_data = 32'd1; rs2_data = 32'd0; rd_addr = 5'd1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("idle_flush.busy", {30'b0, busy, done}, 32'd0);
      check("idle_flush.result", result, 32'd42);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
